// File: rtl/rec_stream_tx_if.sv
// rtl/rec_stream_tx_if.sv - byte-stream handshake bundle for rec_stream_tx
//
// Purpose: groups the valid/ready byte stream produced by rec_stream_tx.
// Signals:
//   data   8  stream byte
//   valid  1  data is valid
//   ready  1  sink accepts the byte when valid && ready
//   last   1  final byte of a frame, qualified by valid
// Modports: master drives data/valid/last and samples ready; slave is the reverse.

interface rec_stream_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       last;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/rec_stream_tx.sv
// rtl/rec_stream_tx.sv - snapshots a record array and streams it out as bytes
//
// Purpose: on load_in, captures rec_in[0:NUM_REC-1] and emits 4 bytes per record
//   ({7'b0,a}, b[0], b[1], b[2]) over a valid/ready stream; optional per-byte bit
//   reversal for ascending-range consumers.
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous active-high reset
//   rec_in         record array to transmit
//   load_in        capture rec_in and start a frame
//   tx             stream master (data, valid, last out; ready in)
//   busy_out       frame in progress
//   load_drop_out  1-cycle pulse: load_in ignored because a frame was in flight
//   frame_cnt_out  completed frames, wraps at 16'hFFFF

package rec_stream_pkg;
    typedef struct packed {
        logic            a;
        logic [2:0][7:0] b;
    } rec_type;
endpackage

module rec_stream_tx
    import rec_stream_pkg::*;
#(
    parameter int NUM_REC   = 2,
    parameter bit ASC_ORDER = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  rec_type            rec_in [0:NUM_REC-1],
    input  logic               load_in,
    rec_stream_tx_if.master    tx,
    output logic               busy_out,
    output logic               load_drop_out,
    output logic [15:0]        frame_cnt_out
);

    localparam logic [2:0] LAST_REC = 3'(NUM_REC - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state;
    state_t next_state;

    // Snapshot is always 8 deep so the 3-bit record index never runs off the end.
    rec_type [7:0] snap;
    rec_type       cur_rec;
    logic [2:0]    rec_idx;
    logic [1:0]    byte_idx;
    logic [15:0]   frame_cnt;
    logic          load_drop;

    logic          accept;
    logic          last_byte;
    logic          capture;
    logic          frame_done;
    logic          drop;
    logic [7:0]    byte_sel;
    logic [7:0]    byte_rev;

    assign accept    = (state == SEND) && tx.ready;
    assign last_byte = (rec_idx == LAST_REC) && (byte_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        frame_done = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (load_in) begin
                    capture    = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (accept && last_byte) begin
                    frame_done = 1'b1;
                    // A load on the closing accept chains the next frame with no bubble.
                    if (load_in) begin
                        capture = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (load_in) begin
                    drop = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap      <= '0;
            rec_idx   <= 3'd0;
            byte_idx  <= 2'd0;
            frame_cnt <= 16'd0;
            load_drop <= 1'b0;
        end else begin
            load_drop <= drop;
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (capture) begin
                for (int k = 0; k < NUM_REC; k++) begin
                    snap[k] <= rec_in[k];
                end
                rec_idx  <= 3'd0;
                byte_idx <= 2'd0;
            end else if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    rec_idx <= rec_idx + 3'd1;
                end
            end
        end
    end

    // Output byte is decoded from the held snapshot and indices, so it stays
    // stable for as long as the sink stalls.
    always_comb begin
        cur_rec = snap[rec_idx];
        case (byte_idx)
            2'd0:    byte_sel = {7'b0, cur_rec.a};
            2'd1:    byte_sel = cur_rec.b[0];
            2'd2:    byte_sel = cur_rec.b[1];
            default: byte_sel = cur_rec.b[2];
        endcase
    end

    always_comb begin
        byte_rev = 8'h00;
        for (int i = 0; i < 8; i++) begin
            byte_rev[i] = byte_sel[7-i];
        end
    end

    assign tx.valid      = (state == SEND);
    assign tx.last       = (state == SEND) && last_byte;
    assign tx.data       = (state == SEND) ? (ASC_ORDER ? byte_rev : byte_sel) : 8'h00;
    assign busy_out      = (state == SEND);
    assign load_drop_out = load_drop;
    assign frame_cnt_out = frame_cnt;

endmodule

// File: tb/tb_rec_stream_tx.sv
// tb/tb_rec_stream_tx.sv - directed self-checking bench for rec_stream_tx

module tb_rec_stream_tx;
    import rec_stream_pkg::*;

    logic        clk;
    logic        rst;
    logic        load;
    rec_type     recs      [0:1];
    rec_type     next_recs [0:1];

    logic        busy, drop;
    logic [15:0] cnt;
    logic        a_busy, a_drop;
    logic [15:0] a_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rec_stream_tx_if s_if ();
    rec_stream_tx_if a_if ();

    rec_stream_tx #(.NUM_REC(2), .ASC_ORDER(1'b0)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .rec_in        (recs),
        .load_in       (load),
        .tx            (s_if.master),
        .busy_out      (busy),
        .load_drop_out (drop),
        .frame_cnt_out (cnt)
    );

    rec_stream_tx #(.NUM_REC(2), .ASC_ORDER(1'b1)) u_asc (
        .clk           (clk),
        .rst           (rst),
        .rec_in        (recs),
        .load_in       (load),
        .tx            (a_if.master),
        .busy_out      (a_busy),
        .load_drop_out (a_drop),
        .frame_cnt_out (a_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic rec_type mk_rec(input logic a, input logic [7:0] b0,
                                       input logic [7:0] b1, input logic [7:0] b2);
        rec_type r;
        r.a    = a;
        r.b[0] = b0;
        r.b[1] = b1;
        r.b[2] = b2;
        return r;
    endfunction

    task automatic set_ready(input logic r);
        s_if.ready = r;
        a_if.ready = r;
    endtask

    task automatic do_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Runs from a negedge where the frame's first byte should already be valid.
    task automatic run_frame(input logic [7:0] exp[$], input logic [7:0] exp_a[$],
                             input int pat, input int drop_at, input bit chain,
                             input logic [15:0] exp_cnt);
        int         i = 0;
        int         cyc = 0;
        bit         drop_pend = 0;
        bit         drop_done = 0;
        bit         stalled = 0;
        logic [7:0] held = 8'h00;
        logic       r;
        while (i < exp.size() && cyc < 100) begin
            check("load_drop", 32'(drop), 32'(drop_pend));
            drop_pend = 0;
            check("valid", 32'(s_if.valid), 32'd1);
            if (stalled) check("hold", 32'(s_if.data), 32'(held));
            r = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
            set_ready(r);
            load = 1'b0;
            if (!drop_done && i == drop_at) begin
                recs[0]   = mk_rec(1'b1, 8'hFF, 8'hFF, 8'hFF);
                recs[1]   = mk_rec(1'b1, 8'hFF, 8'hFF, 8'hFF);
                load      = 1'b1;
                drop_pend = 1;
                drop_done = 1;
            end
            if (r) begin
                check("data", 32'(s_if.data), 32'(exp[i]));
                check("asc_data", 32'(a_if.data), 32'(exp_a[i]));
                check("last", 32'(s_if.last), 32'(i == exp.size() - 1));
                if (chain && i == exp.size() - 1) begin
                    recs = next_recs;
                    load = 1'b1;
                end
                i++;
                stalled = 0;
            end else begin
                stalled = 1;
                held    = s_if.data;
            end
            cyc++;
            @(negedge clk);
        end
        load = 1'b0;
        if (i < exp.size()) check("timeout", 32'(i), 32'(exp.size()));
        check("frame_cnt", 32'(cnt), 32'(exp_cnt));
        if (!chain) check("valid_after", 32'(s_if.valid), 32'd0);
    endtask

    logic [7:0] e1[$], e1a[$], e3[$], e3a[$], e4[$], e4a[$];

    initial begin
        e1  = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h00, 8'h44, 8'h55, 8'h66};
        e1a = '{8'h80, 8'h88, 8'h44, 8'hCC, 8'h00, 8'h22, 8'hAA, 8'h66};
        e3  = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h00, 8'h80, 8'hF0, 8'h0F};
        e3a = '{8'h80, 8'h80, 8'h40, 8'hC0, 8'h00, 8'h01, 8'h0F, 8'hF0};
        e4  = '{8'h01, 8'hA5, 8'h3C, 8'hF0, 8'h01, 8'h01, 8'h02, 8'h04};
        e4a = '{8'h80, 8'hA5, 8'h3C, 8'h0F, 8'h80, 8'h80, 8'h40, 8'h20};

        rst  = 1'b1;
        load = 1'b0;
        set_ready(1'b0);
        recs[0] = mk_rec(1'b0, 8'h00, 8'h00, 8'h00);
        recs[1] = mk_rec(1'b0, 8'h00, 8'h00, 8'h00);
        next_recs = recs;
        @(negedge clk);
        @(negedge clk);

        check("rst_valid", 32'(s_if.valid), 32'd0);
        check("rst_data", 32'(s_if.data), 32'd0);
        check("rst_last", 32'(s_if.last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        rst = 1'b0;

        // 1: basic frame, ready always high
        recs[0] = mk_rec(1'b1, 8'h11, 8'h22, 8'h33);
        recs[1] = mk_rec(1'b0, 8'h44, 8'h55, 8'h66);
        set_ready(1'b1);
        do_load();
        check("busy", 32'(busy), 32'd1);
        run_frame(e1, e1a, 0, -1, 1'b0, 16'd1);

        // 2: same frame with stalls
        do_load();
        run_frame(e1, e1a, 1, -1, 1'b0, 16'd2);

        // 3: bit-reversal vectors
        recs[0] = mk_rec(1'b1, 8'h01, 8'h02, 8'h03);
        recs[1] = mk_rec(1'b0, 8'h80, 8'hF0, 8'h0F);
        set_ready(1'b1);
        do_load();
        check("asc_header", 32'(a_if.data), 32'h80);
        run_frame(e3, e3a, 0, -1, 1'b0, 16'd3);

        // 4: dropped mid-frame load, then chained load on the last accept
        recs[0] = mk_rec(1'b1, 8'h11, 8'h22, 8'h33);
        recs[1] = mk_rec(1'b0, 8'h44, 8'h55, 8'h66);
        next_recs[0] = mk_rec(1'b1, 8'hA5, 8'h3C, 8'hF0);
        next_recs[1] = mk_rec(1'b1, 8'h01, 8'h02, 8'h04);
        set_ready(1'b1);
        do_load();
        run_frame(e1, e1a, 0, 2, 1'b1, 16'd4);
        check("chain_header", 32'(s_if.data), 32'h01);
        run_frame(e4, e4a, 0, -1, 1'b0, 16'd5);

        // 5: reset on the third byte aborts the frame
        recs[0] = mk_rec(1'b1, 8'h11, 8'h22, 8'h33);
        recs[1] = mk_rec(1'b0, 8'h44, 8'h55, 8'h66);
        set_ready(1'b1);
        do_load();
        check("r5_b0", 32'(s_if.data), 32'h01);
        @(negedge clk);
        check("r5_b1", 32'(s_if.data), 32'h11);
        @(negedge clk);
        check("r5_b2", 32'(s_if.data), 32'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("r5_valid", 32'(s_if.valid), 32'd0);
        check("r5_cnt", 32'(cnt), 32'd0);
        check("r5_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("r5_idle", 32'(s_if.valid), 32'd0);
        do_load();
        run_frame(e1, e1a, 0, -1, 1'b0, 16'd1);

        // 6: frame counter wrap
        force u_dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release u_dut.frame_cnt;
        @(negedge clk);
        check("preload_cnt", 32'(cnt), 32'hFFFF);
        do_load();
        run_frame(e1, e1a, 0, -1, 1'b0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
